// File: rtl/branch_predictor_table_if.sv
// branch_predictor_table_if: request, feedback and statistics bundle between core and branch_predictor_table.
interface branch_predictor_table_if #(parameter int ADDR_WIDTH = 32);
    logic                  i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_pc;
    logic [ADDR_WIDTH-1:0] i_req_target;
    logic                  o_req_prediction;
    logic                  o_ready;
    logic                  i_fb_valid;
    logic [ADDR_WIDTH-1:0] i_fb_pc;
    logic                  i_fb_prediction;
    logic                  i_fb_outcome;
    logic [31:0]           o_br_count;
    logic [31:0]           o_miss_count;
    modport master (
        output i_req_valid, i_req_pc, i_req_target, i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome,
        input  o_req_prediction, o_ready, o_br_count, o_miss_count
    );
    modport slave (
        input  i_req_valid, i_req_pc, i_req_target, i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome,
        output o_req_prediction, o_ready, o_br_count, o_miss_count
    );
endinterface

// File: rtl/branch_predictor_table.sv
// branch_predictor_table: PC-indexed table of saturating counters with init sweep, global history and stats.
// Define BP_GSHARE_EN to index the table with pc bits XOR global history (gshare); default is bimodal.
module branch_predictor_table #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 6
) (
    input logic clk,
    input logic rst_n,
    branch_predictor_table_if.slave bp
);
    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [INDEX_BITS-1:0] PTR_LAST = INDEX_BITS'(ENTRIES - 1);
    typedef enum logic {INIT, READY} state_t;
    state_t state, state_next;
    logic [INDEX_BITS-1:0] ptr;
    logic [HIST_BITS-1:0] ghr;
    logic [CTR_BITS-1:0] pht [ENTRIES];
    logic [INDEX_BITS-1:0] req_idx, fb_idx;
    logic [CTR_BITS-1:0] fb_ctr, fb_ctr_next;
    logic [31:0] br_count, miss_count;
    logic unused;
`ifdef BP_GSHARE_EN
    assign req_idx = bp.i_req_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
    assign fb_idx  = bp.i_fb_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
`else
    assign req_idx = bp.i_req_pc[INDEX_BITS+1:2];
    assign fb_idx  = bp.i_fb_pc[INDEX_BITS+1:2];
`endif
    // Bits outside the index window, the informational valid and (in bimodal) the history are not consumed.
    assign unused = ^{bp.i_req_valid, bp.i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], bp.i_req_pc[1:0],
                      bp.i_fb_pc[ADDR_WIDTH-1:INDEX_BITS+2], bp.i_fb_pc[1:0], ghr};
    always_comb begin
        state_next = state;
        if (state == INIT && ptr == PTR_LAST)
            state_next = READY;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= (state == INIT) ? ptr + 1'b1 : ptr;
        end
    end
    assign fb_ctr = pht[fb_idx];
    assign fb_ctr_next = bp.i_fb_outcome ? ((fb_ctr == CTR_MAX) ? fb_ctr : fb_ctr + 1'b1)
                                         : ((fb_ctr == '0) ? fb_ctr : fb_ctr - 1'b1);
    // The table itself needs no reset: the init sweep rewrites every entry.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT)
                pht[ptr] <= CTR_WNT;
            else if (bp.i_fb_valid)
                pht[fb_idx] <= fb_ctr_next;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            ghr <= '0;
        else if (state == READY && bp.i_fb_valid)
            ghr <= HIST_BITS'({ghr, bp.i_fb_outcome});
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count   <= '0;
            miss_count <= '0;
        end else if (bp.i_fb_valid) begin
            br_count <= (&br_count) ? br_count : br_count + 32'd1;
            if (bp.i_fb_prediction != bp.i_fb_outcome)
                miss_count <= (&miss_count) ? miss_count : miss_count + 32'd1;
        end
    end
    assign bp.o_ready = (state == READY);
    assign bp.o_req_prediction = (state == READY) ? pht[req_idx][CTR_BITS-1] : (bp.i_req_target <= bp.i_req_pc);
    assign bp.o_br_count = br_count;
    assign bp.o_miss_count = miss_count;
endmodule

// File: tb/tb_branch_predictor_table.sv
// tb_branch_predictor_table: directed checks of init sweep, fallback, training, saturation, reset and stats.
module tb_branch_predictor_table;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int nfb = 0;
    int nmiss = 0;
    branch_predictor_table_if #(.ADDR_WIDTH(32)) bp();
    branch_predictor_table #(.ADDR_WIDTH(32), .INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bp(bp)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic predict(input string tag, input logic [31:0] pc, input logic exp);
        bp.i_req_pc = pc;
        bp.i_req_target = pc + 32'h10;
        #1;
        check(tag, 32'(bp.o_req_prediction), 32'(exp));
    endtask
    task automatic feedback(input logic [31:0] pc, input logic pred, input logic out);
        bp.i_fb_valid = 1'b1;
        bp.i_fb_pc = pc;
        bp.i_fb_prediction = pred;
        bp.i_fb_outcome = out;
        tick;
        bp.i_fb_valid = 1'b0;
        nfb++;
        if (pred != out) nmiss++;
    endtask
    task automatic wait_ready(input string tag, input int exp);
        int n = 0;
        while (!bp.o_ready && n < 40) begin
            tick;
            n++;
        end
        check(tag, n, exp);
    endtask
    initial begin
        bp.i_req_valid = 1'b1;
        bp.i_req_pc = 32'h100;
        bp.i_req_target = 32'h0F0;
        bp.i_fb_valid = 1'b1;
        bp.i_fb_pc = 32'h40;
        bp.i_fb_prediction = 1'b0;
        bp.i_fb_outcome = 1'b1;
        tick;
        tick;
        check("rst_ready", 32'(bp.o_ready), 0);
        check("rst_br", bp.o_br_count, 0);
        check("rst_miss", bp.o_miss_count, 0);
        check("init_fallback_back", 32'(bp.o_req_prediction), 1);
        bp.i_fb_valid = 1'b0;
        rst_n = 1'b1;
        bp.i_req_target = 32'h110;
        #1;
        check("init_fallback_fwd", 32'(bp.o_req_prediction), 0);
        feedback(32'h40, 1'b0, 1'b1);
        check("init_br", bp.o_br_count, nfb);
        check("init_miss", bp.o_miss_count, nmiss);
        wait_ready("init_len", 15);
        predict("ready_idx0", 32'h40, 1'b0);
        predict("ready_idx9", 32'h64, 1'b0);
`ifndef BP_GSHARE_EN
        feedback(32'h40, 1'b0, 1'b1); predict("t_01_10", 32'h40, 1'b1);
        feedback(32'h40, 1'b1, 1'b1); predict("t_10_11", 32'h40, 1'b1);
        feedback(32'h40, 1'b1, 1'b1); predict("t_sat11", 32'h40, 1'b1);
        feedback(32'h40, 1'b1, 1'b0); predict("n_11_10", 32'h40, 1'b1);
        feedback(32'h40, 1'b1, 1'b0); predict("n_10_01", 32'h40, 1'b0);
        feedback(32'h40, 1'b0, 1'b0); predict("n_01_00", 32'h40, 1'b0);
        feedback(32'h40, 1'b0, 1'b0); predict("n_sat00", 32'h40, 1'b0);
        feedback(32'h40, 1'b0, 1'b1); predict("t_00_01", 32'h40, 1'b0);
        predict("other_idx1", 32'h44, 1'b0);
        bp.i_req_pc = 32'h40;
        bp.i_req_target = 32'h50;
        bp.i_fb_valid = 1'b1;
        bp.i_fb_pc = 32'h40;
        bp.i_fb_prediction = 1'b0;
        bp.i_fb_outcome = 1'b1;
        #1;
        check("same_cycle_old", 32'(bp.o_req_prediction), 0);
        tick;
        bp.i_fb_valid = 1'b0;
        nfb++;
        nmiss++;
        #1;
        check("same_cycle_new", 32'(bp.o_req_prediction), 1);
        predict("alias_0x80", 32'h80, 1'b1);
`else
        feedback(32'h80, 1'b0, 1'b1);
        feedback(32'h80, 1'b0, 1'b1);
        predict("gs_req_idx3", 32'h40, 1'b0);
        feedback(32'h40, 1'b0, 1'b1);
        predict("gs_idx3", 32'h50, 1'b1);
        predict("gs_idx7", 32'h40, 1'b0);
        predict("gs_idx0", 32'h5C, 1'b1);
        predict("gs_idx1", 32'h58, 1'b1);
        predict("gs_idx2", 32'h54, 1'b0);
`endif
        check("run_br", bp.o_br_count, nfb);
        check("run_miss", bp.o_miss_count, nmiss);
        rst_n = 1'b0;
        tick;
        check("rerst_ready", 32'(bp.o_ready), 0);
        check("rerst_br", bp.o_br_count, 0);
        check("rerst_miss", bp.o_miss_count, 0);
        rst_n = 1'b1;
        nfb = 0;
        nmiss = 0;
        wait_ready("reinit_len", 16);
        predict("reinit_idx0", 32'h40, 1'b0);
        predict("reinit_idx1", 32'h44, 1'b0);
        predict("reinit_idx3", 32'h4C, 1'b0);
        for (int i = 0; i < 5; i++) feedback(32'h60, 1'b1, 1'b0);
        feedback(32'h60, 1'b0, 1'b0);
        check("final_miss", bp.o_miss_count, 5);
        check("final_br", bp.o_br_count, 6);
        check("model_miss", bp.o_miss_count, nmiss);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
